// File: rtl/reg_dump.sv
// reg_dump: streams registers lo_addr..hi_addr (wrapping) of an external register file as ready/valid beats.
// Define REG_DUMP_CHECKSUM_EN to append a trailing XOR-checksum beat after the hi_addr register beat.
module reg_dump #(
    parameter int pw = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [pw-1:0] lo_addr,
    input  logic [pw-1:0] hi_addr,
    output logic [pw-1:0] rd_addr,
    input  logic [7:0]    rd_dat,
    output logic [7:0]    out_dat,
    output logic [pw-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;
    logic [pw-1:0] addr_q;
    logic [pw-1:0] hi_q;
    logic [7:0]    out_dat_q;
    logic [pw-1:0] out_addr_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          busy_q;
    logic          done_q;
    logic [pw-1:0] addr_d;
    logic          at_hi_s;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]    csum_q;
    logic [7:0]    csum_d;

    assign csum_d = csum_q ^ out_dat_q;
`endif

    // Next address wraps naturally at 2**pw.
    assign addr_d  = addr_q + pw'(1);
    assign at_hi_s = (addr_q == hi_q);

    assign rd_addr   = addr_q;
    assign out_dat   = out_dat_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Dump sequencer: state, address walk, checksum and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            hi_q        <= '0;
            out_dat_q   <= 8'h00;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= lo_addr;
                        hi_q    <= hi_addr;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum_q  <= 8'h00;
`endif
                    end
                end
                S_LOAD: begin
                    out_dat_q   <= rd_dat;
                    out_addr_q  <= addr_q;
                    out_valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last_q  <= 1'b0;
`else
                    out_last_q  <= at_hi_s;
`endif
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (at_hi_s) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Checksum beat reuses the output registers; valid stays high.
                            csum_q     <= csum_d;
                            out_dat_q  <= csum_d;
                            out_addr_q <= '0;
                            out_last_q <= 1'b1;
                            state_q    <= S_CSUM;
`else
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
`endif
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            csum_q <= csum_d;
`endif
                            addr_q      <= addr_d;
                            out_valid_q <= 1'b0;
                            state_q     <= S_LOAD;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
